// File: rtl/definitions.sv
// Shared types and default sizes for the program-sequencing unit.
package definitions;

  localparam int PC_W_DEF      = 8;
  localparam int STK_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    PC_INC  = 3'd0,
    PC_BRA  = 3'd1,
    PC_BRR  = 3'd2,
    PC_JMP  = 3'd3,
    PC_CALL = 3'd4,
    PC_RET  = 3'd5,
    PC_HALT = 3'd6
  } pc_op_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } pc_state_t;

endpackage

// File: rtl/pc_seq_if.sv
// Decode-stage to sequencer bundle: commands in, PC and stack status out.
interface pc_seq_if #(
  parameter int PC_W      = definitions::PC_W_DEF,
  parameter int STK_DEPTH = definitions::STK_DEPTH_DEF
);
  import definitions::*;

  logic                               stall;
  pc_op_t                             op;
  logic                               taken;
  logic [PC_W-1:0]                    target;
  logic [PC_W-1:0]                    offset;
  logic [PC_W-1:0]                    PC;
  logic                               halted;
  logic [$clog2(STK_DEPTH+1)-1:0]     stk_depth;
  logic                               stk_ovf;
  logic                               stk_unf;

  modport master (
    output stall, op, taken, target, offset,
    input  PC, halted, stk_depth, stk_ovf, stk_unf
  );

  modport slave (
    input  stall, op, taken, target, offset,
    output PC, halted, stk_depth, stk_ovf, stk_unf
  );

endinterface

// File: rtl/pc_ret_stack.sv
// Return-address LIFO. The body only exists when PC_RET_STACK_EN is defined,
// so a stackless build carries no stray top-level module.
`ifdef PC_RET_STACK_EN
module pc_ret_stack #(
  parameter int PC_W      = 8,
  parameter int STK_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [PC_W-1:0]                data_i,
  output logic [PC_W-1:0]                top_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(STK_DEPTH+1)-1:0] depth_o
);
  localparam int DW    = $clog2(STK_DEPTH+1);
  localparam int IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

  logic [PC_W-1:0]  mem_q [STK_DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic [IDX_W-1:0] wr_ptr, rd_ptr;

  // Entry count doubles as the write pointer; the top sits one below it.
  assign wr_ptr  = IDX_W'(depth_q);
  assign rd_ptr  = IDX_W'(depth_q - DW'(1));
  assign full_o  = (depth_q == DW'(STK_DEPTH));
  assign empty_o = (depth_q == '0);
  assign top_o   = mem_q[rd_ptr];
  assign depth_o = depth_q;

  always_comb begin
    depth_d = depth_q;
    if (push_i && !full_o)
      depth_d = depth_q + DW'(1);
    else if (pop_i && !empty_o)
      depth_d = depth_q - DW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      depth_q <= '0;
    else
      depth_q <= depth_d;
  end

  always_ff @(posedge clk) begin
    if (!reset && push_i && !full_o)
      mem_q[wr_ptr] <= data_i;
  end

endmodule
`endif

// File: rtl/pc_seq.sv
// Program-sequencing unit: next instruction address, branches, call/return, halt.
// Define PC_RET_STACK_EN to build the hardware return-address stack.
//
// state | meaning
// RUN   | PC advances under op each unstalled cycle
// HALT  | PC, stack and flags frozen until reset
module pc_seq
  import definitions::*;
#(
  parameter int              PC_W       = PC_W_DEF,
  parameter int              STK_DEPTH  = STK_DEPTH_DEF,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic    clk,
  input  logic    reset,
  pc_seq_if.slave bus
);
  pc_state_t       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, pc_rel;

  assign pc_inc = pc_q + PC_W'(1);
  assign pc_rel = pc_q + bus.offset;

`ifdef PC_RET_STACK_EN
  localparam int DW = $clog2(STK_DEPTH+1);

  logic            push, pop, stk_full, stk_empty;
  logic [PC_W-1:0] stk_top;
  logic [DW-1:0]   stk_depth;
  logic            ovf_q, ovf_d, unf_q, unf_d;

  pc_ret_stack #(.PC_W(PC_W), .STK_DEPTH(STK_DEPTH)) u_stack (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pc_inc),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty),
    .depth_o (stk_depth)
  );
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_RET_STACK_EN
    push    = 1'b0;
    pop     = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
`endif
    if (state_q == RUN && !bus.stall) begin
      case (bus.op)
        PC_INC:  pc_d = pc_inc;
        PC_BRA:  pc_d = bus.taken ? bus.target : pc_inc;
        PC_BRR:  pc_d = bus.taken ? pc_rel : pc_inc;
        PC_JMP:  pc_d = bus.target;
        PC_CALL: begin
          pc_d = bus.target;
`ifdef PC_RET_STACK_EN
          if (stk_full) ovf_d = 1'b1;
          else          push  = 1'b1;
`endif
        end
        PC_RET: begin
`ifdef PC_RET_STACK_EN
          if (stk_empty) begin
            pc_d  = pc_inc;
            unf_d = 1'b1;
          end else begin
            pc_d = stk_top;
            pop  = 1'b1;
          end
`else
          pc_d = pc_inc;
`endif
        end
        PC_HALT: state_d = HALT;
        default: pc_d = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= START_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PC_RET_STACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.stk_depth = stk_depth;
  assign bus.stk_ovf   = ovf_q;
  assign bus.stk_unf   = unf_q;
`else
  assign bus.stk_depth = '0;
  assign bus.stk_ovf   = 1'b0;
  assign bus.stk_unf   = 1'b0;
`endif

  assign bus.PC     = pc_q;
  assign bus.halted = (state_q == HALT);

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: each driven cycle queues its expected outputs,
// a monitor compares them after the following clock edge.
module tb_pc_seq;
  import definitions::*;

  localparam int PW = 8;
  localparam int SD = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pc_seq_if #(.PC_W(PW), .STK_DEPTH(SD)) bus ();

  pc_seq #(.PC_W(PW), .STK_DEPTH(SD), .START_ADDR(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [7:0] pc;
    logic       halted;
    logic [2:0] depth;
    logic       ovf;
    logic       unf;
    int         id;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_steps  = 0;

  task automatic step(input logic rst, input logic stl, input pc_op_t op,
                      input logic tk, input logic [7:0] tgt, input logic [7:0] off,
                      input logic [7:0] e_pc, input logic e_h, input logic [2:0] e_d,
                      input logic e_o, input logic e_u);
    exp_t e;
    @(negedge clk);
    reset      = rst;
    bus.stall  = stl;
    bus.op     = op;
    bus.taken  = tk;
    bus.target = tgt;
    bus.offset = off;
    e.pc     = e_pc;
    e.halted = e_h;
    e.depth  = e_d;
    e.ovf    = e_o;
    e.unf    = e_u;
    e.id     = n_steps;
    n_steps++;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL step %0d %s: got %0h expected %0h", id, nm, act, exp);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("PC",        e.id, bus.PC,                  e.pc);
        chk("halted",    e.id, {7'd0, bus.halted},      {7'd0, e.halted});
        chk("stk_depth", e.id, {5'd0, bus.stk_depth},   {5'd0, e.depth});
        chk("stk_ovf",   e.id, {7'd0, bus.stk_ovf},     {7'd0, e.ovf});
        chk("stk_unf",   e.id, {7'd0, bus.stk_unf},     {7'd0, e.unf});
      end
    end
  end

  initial begin
    bus.stall  = 1'b0;
    bus.op     = PC_INC;
    bus.taken  = 1'b0;
    bus.target = 8'h00;
    bus.offset = 8'h00;

    // reset and increment
    step(1, 0, PC_INC,  0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    step(0, 0, PC_INC,  0, 8'h00, 8'h00, 8'h01, 0, 0, 0, 0);
    step(0, 0, PC_INC,  0, 8'h00, 8'h00, 8'h02, 0, 0, 0, 0);
    step(0, 0, PC_INC,  0, 8'h00, 8'h00, 8'h03, 0, 0, 0, 0);
    // absolute branch
    step(0, 0, PC_JMP,  0, 8'h05, 8'h00, 8'h05, 0, 0, 0, 0);
    step(0, 0, PC_BRA,  1, 8'h40, 8'h00, 8'h40, 0, 0, 0, 0);
    step(0, 0, PC_JMP,  0, 8'h05, 8'h00, 8'h05, 0, 0, 0, 0);
    step(0, 0, PC_BRA,  0, 8'h40, 8'h00, 8'h06, 0, 0, 0, 0);
    // relative branch and wrap
    step(0, 0, PC_JMP,  0, 8'h10, 8'h00, 8'h10, 0, 0, 0, 0);
    step(0, 0, PC_BRR,  1, 8'h00, 8'hFC, 8'h0C, 0, 0, 0, 0);
    step(0, 0, PC_BRR,  0, 8'h00, 8'hFC, 8'h0D, 0, 0, 0, 0);
    step(0, 0, PC_JMP,  0, 8'hFF, 8'h00, 8'hFF, 0, 0, 0, 0);
    step(0, 0, PC_INC,  0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    step(0, 0, PC_BRR,  1, 8'h00, 8'h05, 8'h05, 0, 0, 0, 0);
    step(0, 0, PC_BRR,  1, 8'h00, 8'hF0, 8'hF5, 0, 0, 0, 0);
    step(0, 0, pc_op_t'(3'd7), 1, 8'h99, 8'h00, 8'hF6, 0, 0, 0, 0);
    // stall
    step(0, 1, PC_JMP,  0, 8'h80, 8'h00, 8'hF6, 0, 0, 0, 0);
    step(0, 1, PC_HALT, 0, 8'h00, 8'h00, 8'hF6, 0, 0, 0, 0);

`ifdef PC_RET_STACK_EN
    // nested calls to overflow, then unwind to underflow
    step(0, 0, PC_JMP,  0, 8'h01, 8'h00, 8'h01, 0, 0, 0, 0);
    step(0, 0, PC_CALL, 0, 8'h10, 8'h00, 8'h10, 0, 1, 0, 0);
    step(0, 0, PC_CALL, 0, 8'h20, 8'h00, 8'h20, 0, 2, 0, 0);
    step(0, 0, PC_CALL, 0, 8'h30, 8'h00, 8'h30, 0, 3, 0, 0);
    step(0, 0, PC_CALL, 0, 8'h40, 8'h00, 8'h40, 0, 4, 0, 0);
    step(0, 0, PC_CALL, 0, 8'h50, 8'h00, 8'h50, 0, 4, 1, 0);
    step(0, 0, PC_RET,  0, 8'h00, 8'h00, 8'h31, 0, 3, 1, 0);
    step(0, 0, PC_RET,  0, 8'h00, 8'h00, 8'h21, 0, 2, 1, 0);
    step(0, 0, PC_RET,  0, 8'h00, 8'h00, 8'h11, 0, 1, 1, 0);
    step(0, 0, PC_RET,  0, 8'h00, 8'h00, 8'h02, 0, 0, 1, 0);
    step(0, 0, PC_RET,  0, 8'h00, 8'h00, 8'h03, 0, 0, 1, 1);
    step(0, 1, PC_CALL, 0, 8'h77, 8'h00, 8'h03, 0, 0, 1, 1);
    // reset discards a live stack entry
    step(0, 0, PC_CALL, 0, 8'h60, 8'h00, 8'h60, 0, 1, 1, 1);
    step(1, 0, PC_RET,  0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    step(0, 0, PC_RET,  0, 8'h00, 8'h00, 8'h01, 0, 0, 0, 1);
    step(1, 0, PC_INC,  0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    // back-to-back call/return
    step(0, 0, PC_CALL, 0, 8'h70, 8'h00, 8'h70, 0, 1, 0, 0);
    step(0, 0, PC_RET,  0, 8'h00, 8'h00, 8'h01, 0, 0, 0, 0);
`else
    // without a stack, call is a jump and return is an increment
    step(0, 0, PC_CALL, 0, 8'h30, 8'h00, 8'h30, 0, 0, 0, 0);
    step(0, 0, PC_RET,  0, 8'h00, 8'h00, 8'h31, 0, 0, 0, 0);
    step(0, 0, PC_RET,  0, 8'h00, 8'h00, 8'h32, 0, 0, 0, 0);
`endif

    // halt and recovery by reset
    step(0, 0, PC_JMP,  0, 8'h22, 8'h00, 8'h22, 0, 0, 0, 0);
    step(0, 0, PC_HALT, 0, 8'h00, 8'h00, 8'h22, 1, 0, 0, 0);
    step(0, 0, PC_JMP,  0, 8'h80, 8'h00, 8'h22, 1, 0, 0, 0);
    step(0, 0, PC_BRR,  1, 8'h00, 8'h10, 8'h22, 1, 0, 0, 0);
    step(0, 0, PC_RET,  0, 8'h00, 8'h00, 8'h22, 1, 0, 0, 0);
    step(0, 1, PC_INC,  0, 8'h00, 8'h00, 8'h22, 1, 0, 0, 0);
    step(1, 0, PC_INC,  0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    step(0, 0, PC_INC,  0, 8'h00, 8'h00, 8'h01, 0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
